// File: rtl/clock_frame_serializer_if.sv
// Display-link bundle between a frame source and the serializer that drives the LED shifter.
interface clock_frame_serializer_if #(
    parameter int unsigned BRIGHT_W = 12
);
    logic                start;
    logic [3:0]          digit1;
    logic [3:0]          digit2;
    logic [3:0]          digit3;
    logic [3:0]          digit4;
    logic [1:0]          col1;
    logic [1:0]          col2;
    logic [1:0]          col3;
    logic [1:0]          col4;
    logic [6:0]          anode_mask;
    logic [BRIGHT_W-1:0] bright;
    logic                busy;
    logic                done;
    logic                sclk;
    logic                sdata;
    logic                latch;
    logic                pwm;

    modport master (
        output start, digit1, digit2, digit3, digit4,
        output col1, col2, col3, col4, anode_mask, bright,
        input  busy, done, sclk, sdata, latch, pwm
    );

    modport slave (
        input  start, digit1, digit2, digit3, digit4,
        input  col1, col2, col3, col4, anode_mask, bright,
        output busy, done, sclk, sdata, latch, pwm
    );
endinterface

// File: rtl/clock_frame_serializer.sv
// Serialises a 96-bit digit frame plus a brightness word into the LED display shifter,
// strobing latch after the frame and pwm after the brightness word.
module clock_frame_serializer #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned BRIGHT_W = 12
) (
    input logic                     clk,
    input logic                     rst,
    clock_frame_serializer_if.slave bus
);
    localparam int unsigned FRAME_W = 96;
    localparam int unsigned CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W   = 7;

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT, S_LATCH, S_BSHIFT, S_PWM, S_DONE
    } state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [23:0] digit_field(input logic [3:0] d, input logic [1:0] c,
                                                input logic [6:0] an);
        logic [6:0] seg;
        seg = seg_decode(d);
        return {1'b0, seg & {7{c[1]}}, 1'b0, seg & {7{c[0]}}, 1'b0, an};
    endfunction

    state_t              r_state, w_state_nx;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
    logic                r_phase, w_phase_nx;
    logic [BIT_W-1:0]    r_bits, w_bits_nx;
    logic [FRAME_W-1:0]  r_frame, w_frame_nx;
    logic [BRIGHT_W-1:0] r_bright, w_bright_nx;
    logic                r_busy, w_busy_nx;
    logic                r_done, w_done_nx;
    logic                r_sclk, w_sclk_nx;
    logic                r_sdata, w_sdata_nx;
    logic                r_latch, w_latch_nx;
    logic                r_pwm, w_pwm_nx;
    logic                w_tick;

    assign w_tick = (r_cnt == CNT_W'(CLK_DIV - 1));

    // Each serial phase spends one tick with sclk low (data set up) and one tick high.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_phase_nx  = r_phase;
        w_bits_nx   = r_bits;
        w_frame_nx  = r_frame;
        w_bright_nx = r_bright;
        w_busy_nx   = r_busy;
        w_done_nx   = 1'b0;
        w_sclk_nx   = r_sclk;
        w_sdata_nx  = r_sdata;
        w_latch_nx  = r_latch;
        w_pwm_nx    = r_pwm;
        if (r_busy) begin
            w_cnt_nx = w_tick ? '0 : r_cnt + CNT_W'(1);
        end
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_frame_nx  = {digit_field(bus.digit4, bus.col4, bus.anode_mask),
                                   digit_field(bus.digit3, bus.col3, bus.anode_mask),
                                   digit_field(bus.digit2, bus.col2, bus.anode_mask),
                                   digit_field(bus.digit1, bus.col1, bus.anode_mask)};
                    w_bright_nx = bus.bright;
                    w_state_nx  = S_SHIFT;
                    w_busy_nx   = 1'b1;
                    w_cnt_nx    = '0;
                    w_phase_nx  = 1'b0;
                    w_bits_nx   = '0;
                end
            end
            S_SHIFT: begin
                if (w_tick) begin
                    if (!r_phase) begin
                        w_sdata_nx = r_frame[FRAME_W-1];
                        w_frame_nx = {r_frame[FRAME_W-2:0], 1'b0};
                        w_sclk_nx  = 1'b0;
                        w_phase_nx = 1'b1;
                    end else begin
                        w_sclk_nx  = 1'b1;
                        w_phase_nx = 1'b0;
                        if (r_bits == BIT_W'(FRAME_W - 1)) begin
                            w_bits_nx  = '0;
                            w_state_nx = S_LATCH;
                        end else begin
                            w_bits_nx = r_bits + BIT_W'(1);
                        end
                    end
                end
            end
            S_LATCH: begin
                if (w_tick) begin
                    if (!r_phase) begin
                        w_latch_nx = 1'b1;
                        w_sclk_nx  = 1'b0;
                        w_phase_nx = 1'b1;
                    end else begin
                        w_latch_nx = 1'b0;
                        w_phase_nx = 1'b0;
                        w_state_nx = S_BSHIFT;
                    end
                end
            end
            S_BSHIFT: begin
                if (w_tick) begin
                    if (!r_phase) begin
                        w_sdata_nx  = r_bright[BRIGHT_W-1];
                        w_bright_nx = {r_bright[BRIGHT_W-2:0], 1'b0};
                        w_sclk_nx   = 1'b0;
                        w_phase_nx  = 1'b1;
                    end else begin
                        w_sclk_nx  = 1'b1;
                        w_phase_nx = 1'b0;
                        if (r_bits == BIT_W'(BRIGHT_W - 1)) begin
                            w_bits_nx  = '0;
                            w_state_nx = S_PWM;
                        end else begin
                            w_bits_nx = r_bits + BIT_W'(1);
                        end
                    end
                end
            end
            S_PWM: begin
                if (w_tick) begin
                    if (!r_phase) begin
                        w_pwm_nx   = 1'b1;
                        w_sclk_nx  = 1'b0;
                        w_phase_nx = 1'b1;
                    end else begin
                        w_pwm_nx   = 1'b0;
                        w_phase_nx = 1'b0;
                        w_state_nx = S_DONE;
                        w_busy_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                        w_cnt_nx   = '0;
                    end
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
            r_bits   <= '0;
            r_frame  <= '0;
            r_bright <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sclk   <= 1'b0;
            r_sdata  <= 1'b0;
            r_latch  <= 1'b0;
            r_pwm    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_phase  <= w_phase_nx;
            r_bits   <= w_bits_nx;
            r_frame  <= w_frame_nx;
            r_bright <= w_bright_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
            r_sclk   <= w_sclk_nx;
            r_sdata  <= w_sdata_nx;
            r_latch  <= w_latch_nx;
            r_pwm    <= w_pwm_nx;
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.sclk  = r_sclk;
    assign bus.sdata = r_sdata;
    assign bus.latch = r_latch;
    assign bus.pwm   = r_pwm;
endmodule

// File: tb/tb_clock_frame_serializer.sv
// Bench for clock_frame_serializer: table of frames, bit-stream scoreboard and a display-shifter model.
module tb_clock_frame_serializer;
    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned BRIGHT_W = 12;
    localparam int          DONE_CYC = 1 + 220 * CLK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clock_frame_serializer_if #(.BRIGHT_W(BRIGHT_W)) bus ();

    clock_frame_serializer #(.CLK_DIV(CLK_DIV), .BRIGHT_W(BRIGHT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  d1, d2, d3, d4;
        logic [1:0]  c1, c2, c3, c4;
        logic [6:0]  mask;
        logic [11:0] bright;
        logic [95:0] frame;
    } vec_t;

    vec_t vecs[4];

    int n_checks = 0;
    int n_pass   = 0;

    logic        exp_q[$];
    int          rise_cnt = 0, latch_cnt = 0, pwm_cnt = 0, latch_at = 0, pwm_at = 0, viol = 0;
    logic [95:0] sr = '0, frame_model = '0;
    logic [11:0] bright_model = '0;
    logic        prev_sclk = 1'b0, prev_sdata = 1'b0, prev_latch = 1'b0, prev_pwm = 1'b0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Display shifter model plus stream scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        logic b;
        if (bus.sclk === 1'b1 && prev_sclk === 1'b0) begin
            rise_cnt++;
            sr = {sr[94:0], bus.sdata};
            if (exp_q.size() == 0) begin
                check("stream_extra_bit", 96'd1, 96'd0);
            end else begin
                b = exp_q.pop_front();
                check("stream_bit", 96'(bus.sdata), 96'(b));
            end
        end
        if (bus.latch === 1'b1 && prev_latch === 1'b0) begin
            latch_cnt++;
            latch_at    = rise_cnt;
            frame_model = sr;
        end
        if (bus.pwm === 1'b1 && prev_pwm === 1'b0) begin
            pwm_cnt++;
            pwm_at       = rise_cnt;
            bright_model = sr[11:0];
        end
        if ((bus.latch === 1'b1 || bus.pwm === 1'b1) && bus.sclk === 1'b1) viol++;
        if (prev_sclk === 1'b1 && bus.sclk === 1'b1 && bus.sdata !== prev_sdata) viol++;
        prev_sclk  = bus.sclk;
        prev_sdata = bus.sdata;
        prev_latch = bus.latch;
        prev_pwm   = bus.pwm;
    end

    task automatic drive_vec(input vec_t v);
        bus.digit1 = v.d1; bus.digit2 = v.d2; bus.digit3 = v.d3; bus.digit4 = v.d4;
        bus.col1 = v.c1; bus.col2 = v.c2; bus.col3 = v.c3; bus.col4 = v.c4;
        bus.anode_mask = v.mask;
        bus.bright = v.bright;
    endtask

    task automatic push_expected(input vec_t v);
        for (int i = 95; i >= 0; i--) exp_q.push_back(v.frame[i]);
        for (int i = 11; i >= 0; i--) exp_q.push_back(v.bright[i]);
    endtask

    task automatic run_frame(input int idx, input bit dbl_start, input bit start_on_done);
        vec_t v;
        int   base_rise, lat0, pwm0, busy_cycles, done_cyc, done_cnt;
        v = vecs[idx];
        @(negedge clk);
        drive_vec(v);
        bus.start = 1'b1;
        push_expected(v);
        base_rise = rise_cnt; lat0 = latch_cnt; pwm0 = pwm_cnt;
        busy_cycles = 0; done_cyc = -1; done_cnt = 0;
        for (int c = 1; c <= DONE_CYC + 300; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c == 1) check("busy_at_cycle1", 96'(bus.busy), 96'd1);
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                if (start_on_done) bus.start = 1'b1;
            end
            if (dbl_start && c == 400) begin
                bus.start  = 1'b1;
                bus.digit1 = 4'd9;
                bus.digit4 = 4'd0;
                bus.bright = ~v.bright;
            end
        end
        check("done_cycle", 96'(done_cyc), 96'(DONE_CYC));
        check("done_count", 96'(done_cnt), 96'd1);
        check("busy_cycles", 96'(busy_cycles), 96'(DONE_CYC - 1));
        check("rises_before_latch", 96'(latch_at - base_rise), 96'd96);
        check("rises_before_pwm", 96'(pwm_at - latch_at), 96'd12);
        check("latch_pulses", 96'(latch_cnt - lat0), 96'd1);
        check("pwm_pulses", 96'(pwm_cnt - pwm0), 96'd1);
        check("shifter_frame", frame_model, v.frame);
        check("shifter_bright", 96'(bright_model), 96'(v.bright));
        check("stream_leftover", 96'(exp_q.size()), 96'd0);
        check("timing_violations", 96'(viol), 96'd0);
        exp_q.delete();
    endtask

    initial begin
        int   bad;
        vec_t v;
        vecs[0] = '{d1: 4'd1, d2: 4'd2, d3: 4'd3, d4: 4'd4, c1: 2'b01, c2: 2'b01, c3: 2'b01,
                    c4: 2'b01, mask: 7'h7F, bright: 12'hA5C,
                    frame: 96'h00667F_004F7F_005B7F_00067F};
        vecs[1] = '{d1: 4'd1, d2: 4'd12, d3: 4'd3, d4: 4'd4, c1: 2'b01, c2: 2'b11, c3: 2'b01,
                    c4: 2'b01, mask: 7'h7F, bright: 12'hA5C,
                    frame: 96'h00667F_004F7F_00007F_00067F};
        vecs[2] = '{d1: 4'd8, d2: 4'd0, d3: 4'd5, d4: 4'd9, c1: 2'b10, c2: 2'b11, c3: 2'b00,
                    c4: 2'b10, mask: 7'h01, bright: 12'h123,
                    frame: 96'h6F0001_000001_3F3F01_7F0001};
        vecs[3] = '{d1: 4'd7, d2: 4'd6, d3: 4'd15, d4: 4'd1, c1: 2'b01, c2: 2'b10, c3: 2'b11,
                    c4: 2'b01, mask: 7'h55, bright: 12'h800,
                    frame: 96'h000655_000055_7D0055_000755};

        bus.start = 1'b0;
        drive_vec(vecs[0]);
        repeat (3) @(negedge clk);
        check("reset_outputs", 96'({bus.busy, bus.done, bus.sclk, bus.sdata, bus.latch, bus.pwm}), 96'd0);
        rst = 1'b0;

        // Idle: nothing moves without a start.
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ({bus.busy, bus.done, bus.sclk, bus.sdata, bus.latch, bus.pwm} !== 6'd0) bad++;
        end
        check("idle_outputs", 96'(bad), 96'd0);
        check("idle_sclk_edges", 96'(rise_cnt), 96'd0);

        run_frame(0, 1'b1, 1'b1);
        for (int i = 1; i < 4; i++) run_frame(i, 1'b0, 1'b0);

        // Reset in the middle of the frame shift aborts with no strobes afterwards.
        v = vecs[2];
        @(negedge clk);
        drive_vec(v);
        bus.start = 1'b1;
        push_expected(v);
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("busy_before_abort", 96'(bus.busy), 96'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", 96'({bus.busy, bus.done, bus.sclk, bus.sdata, bus.latch, bus.pwm}), 96'd0);
        rst = 1'b0;
        exp_q.delete();
        begin
            int lat0, pwm0;
            lat0 = latch_cnt; pwm0 = pwm_cnt;
            repeat (1000) @(negedge clk);
            check("abort_no_latch", 96'(latch_cnt - lat0), 96'd0);
            check("abort_no_pwm", 96'(pwm_cnt - pwm0), 96'd0);
            check("abort_idle_busy", 96'(bus.busy), 96'd0);
        end
        run_frame(0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
